edge_req_arbiter: RTL and testbench

- Round-robin arbiter that turns N asynchronous-looking level request lines into serviced, one-at-a-time grants for a shared resource.
- Each channel passes through a per-channel rising-edge detector; every detected edge latches a pending flag.
- A two-state controller grants pending channels in rotating order and holds each grant until the consumer signals done.

---
 rtl/edge_req_arbiter_pkg.sv | 21 ++
 rtl/edge_req_arbiter_edge_tick.sv | 47 ++++
 rtl/edge_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_edge_req_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_req_arbiter_pkg.sv
// Shared types and default sizing for the edge-triggered request arbiter.
// Package name: edge_arb_pkg.
package edge_arb_pkg;

  // Default channel count and grant timeout (cycles).
  localparam int ARB_N_DEF       = 4;
  localparam int ARB_TIMEOUT_DEF = 16;

  // Arbiter controller: waiting for work, or holding one grant.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Per-channel edge detector: last sampled level low / high.
  typedef enum logic {
    ZERO = 1'b0,
    ONE  = 1'b1
  } edge_state_t;

endpackage

// File: rtl/edge_req_arbiter_edge_tick.sv
// Single-channel rising-edge detector. tick is combinational: it is high
// while the detector is in ZERO and the level is already high, so the
// edge is consumed at the same clock edge that moves the state to ONE.
module edge_tick
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic tick
);

  edge_state_t state_q;
  edge_state_t state_d;

  // Detector state register, synchronous active-low reset to ZERO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ZERO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and edge tick: one tick per rising level, none while held.
  always_comb begin
    state_d = state_q;
    tick    = 1'b0;
    case (state_q)
      ZERO: begin
        if (level) begin
          tick    = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (!level) begin
          state_d = ZERO;
        end
      end
      default: begin
        state_d = ZERO;
      end
    endcase
  end

endmodule

// File: rtl/edge_req_arbiter.sv
// Round-robin arbiter for N level request lines. Every rising edge on a
// channel latches a pending flag; a two-state controller grants pending
// channels one at a time in rotating order and holds each grant until the
// consumer signals done.
//
// Optional feature: define ARB_TIMEOUT_EN to abort a grant that has not
// seen done after TIMEOUT cycles (timeout pulses). Without the macro the
// grant waits indefinitely and timeout is tied low.
module edge_req_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N       = ARB_N_DEF,
  parameter int IDW     = $clog2(N),
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   level,
  input  logic           done,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   pend,
  output logic           overflow,
  output logic           timeout
);

  logic [N-1:0]   tick;
  logic [N-1:0]   clr;
  logic [N-1:0]   pend_d;
  logic           ovf_d;

  arb_state_t     state_q;
  arb_state_t     state_d;
  logic           gv_d;
  logic [IDW-1:0] gid_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;

  logic           found;
  logic [IDW-1:0] sel;
  logic           retire;
  logic           tmo_hit;

  // One edge detector per request line.
  for (genvar i = 0; i < N; i++) begin : g_edge
    edge_tick u_tick (
      .clk   (clk),
      .rst   (rst),
      .level (level[i]),
      .tick  (tick[i])
    );
  end

  // Round-robin search: first pending channel after ptr, wrapping at N.
  // Two ascending passes (above ptr, then up to ptr) give the modulo-N
  // order without any 2^IDW wrap, so non-power-of-2 N is handled.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && pend[j] && (j > int'(ptr_q))) begin
        found = 1'b1;
        sel   = IDW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && pend[j] && (j <= int'(ptr_q))) begin
        found = 1'b1;
        sel   = IDW'(j);
      end
    end
  end

  // Controller next state: issue a grant from IDLE, retire it on done or
  // on timeout (done wins when both happen at the same edge).
  always_comb begin
    state_d = state_q;
    gv_d    = gnt_valid;
    gid_d   = gnt_id;
    ptr_d   = ptr_q;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gv_d    = 1'b1;
          gid_d   = sel;
        end
      end
      GRANT: begin
        if (done || tmo_hit) begin
          retire = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (retire) begin
      state_d = IDLE;
      gv_d    = 1'b0;
      ptr_d   = gnt_id;
    end
  end

  // Pending flags: a new edge beats a clear on the same channel, and only
  // an edge on a channel that stays pending counts as an overflow.
  always_comb begin
    clr    = retire ? (N'(1) << gnt_id) : '0;
    pend_d = tick | (pend & ~clr);
    ovf_d  = |(tick & pend & ~clr);
  end

  // Controller, pointer, grant and pending registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr_q     <= IDW'(N - 1);
      pend      <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_valid <= gv_d;
      gnt_id    <= gid_d;
      ptr_q     <= ptr_d;
      pend      <= pend_d;
      overflow  <= ovf_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tmo_hit = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Grant age counter: zero on entry to GRANT, counts cycles without done;
  // timeout pulses only when the limit retires the grant and done is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= tmo_hit && !done;
      if (state_q != GRANT) begin
        cnt_q <= '0;
      end else if (!done && !tmo_hit) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_edge_req_arbiter.sv
// Self-checking bench for edge_req_arbiter: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_edge_req_arbiter;

  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 16;
  localparam int BW      = N + IDW + 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   level;
  logic           done;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   pend;
  logic           overflow;
  logic           timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [N-1:0] m_prev;
  logic [N-1:0] m_pend;
  logic         m_gv;
  logic         m_ovf;
  logic         m_tmo;
  int           m_gid;
  int           m_ptr;
  int           m_age;

  always #5 clk = ~clk;

  edge_req_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .level     (level),
    .done      (done),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .pend      (pend),
    .overflow  (overflow),
    .timeout   (timeout)
  );

  // Model of one clock edge, from the rules: rising level -> pending,
  // rotating pick after ptr, done/timeout retires, new edge beats clear.
  task automatic model_edge(input logic r, input logic [N-1:0] lv, input logic d);
    logic [N-1:0] rise;
    int rel;
    int pick;
    int idx;
    if (!r) begin
      m_prev = '0; m_pend = '0; m_gv = 1'b0; m_gid = 0;
      m_ptr = N - 1; m_age = 0; m_ovf = 1'b0; m_tmo = 1'b0;
      return;
    end
    rise  = lv & ~m_prev;
    rel   = -1;
    m_tmo = 1'b0;
    if (m_gv) begin
      if (d) rel = m_gid;
`ifdef ARB_TIMEOUT_EN
      else if (m_age == TIMEOUT - 1) begin
        rel   = m_gid;
        m_tmo = 1'b1;
      end else m_age++;
`endif
    end else begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (pick < 0 && m_pend[idx]) pick = idx;
      end
      if (pick >= 0) begin
        m_gv  = 1'b1;
        m_gid = pick;
        m_age = 0;
      end
    end
    m_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rise[i] && m_pend[i] && i != rel) m_ovf = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (i == rel) m_pend[i] = 1'b0;
    end
    m_pend = m_pend | rise;
    if (rel >= 0) begin
      m_ptr = rel;
      m_gv  = 1'b0;
    end
    m_prev = lv;
  endtask

  // Drive one cycle at the falling edge, advance the model at the rising
  // edge, and leave time just after the edge for sampling.
  task automatic cyc(input logic r, input logic [N-1:0] lv, input logic d);
    @(negedge clk);
    rst   = r;
    level = lv;
    done  = d;
    @(posedge clk);
    model_edge(r, lv, d);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, 1'b0);
  endtask

  function automatic logic [BW-1:0] obs_vec();
    return {gnt_valid, (gnt_valid ? gnt_id : IDW'(0)), pend, overflow, timeout};
  endfunction

  function automatic logic [BW-1:0] exp_vec();
    return {m_gv, (m_gv ? IDW'(m_gid) : IDW'(0)), m_pend, m_ovf, m_tmo};
  endfunction

  task automatic test_reset();
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '1, 1'b1);
    n_tests++;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", obs_vec(), {BW{1'b0}});
    end
    cyc(1'b1, '0, 1'b0);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_idle: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    int extra;
    do_reset();
    for (int c = 1; c <= 4; c++) cyc(1'b1, '0, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0);
    n_tests++;
    if (pend !== 4'b0100 || gnt_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_pend: got pend=%b gv=%b want pend=0100 gv=0", pend, gnt_valid);
    end
    cyc(1'b1, 4'b0100, 1'b0);
    n_tests++;
    if (gnt_valid !== 1'b1 || gnt_id !== 2'd2) begin
      n_fail++; $display("FAIL single_grant: got gv=%b id=%0d want gv=1 id=2", gnt_valid, gnt_id);
    end
    cyc(1'b1, 4'b0100, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0);
    n_tests++;
    if (gnt_valid !== 1'b1 || gnt_id !== 2'd2) begin
      n_fail++; $display("FAIL single_hold: got gv=%b id=%0d want gv=1 id=2", gnt_valid, gnt_id);
    end
    cyc(1'b1, 4'b0100, 1'b1);
    n_tests++;
    if (pend !== 4'b0000 || gnt_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got pend=%b gv=%b want pend=0000 gv=0", pend, gnt_valid);
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b1, 4'b0100, 1'b0);
      if (gnt_valid) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL single_no_regrant: got %0d grant cycles want 0", extra);
    end
  endtask

  task automatic test_round_robin();
    int waited;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      cyc(1'b1, 4'hF, 1'b0);
      for (int g = 0; g < N; g++) begin
        waited = 0;
        while (!gnt_valid && waited < 8) begin
          cyc(1'b1, 4'hF, 1'b0);
          waited++;
        end
        n_tests++;
        if (gnt_valid !== 1'b1 || gnt_id !== IDW'(g)) begin
          n_fail++; $display("FAIL rr_order pass%0d: got gv=%b id=%0d want gv=1 id=%0d", pass, gnt_valid, gnt_id, g);
        end
        cyc(1'b1, 4'hF, 1'b0);
        cyc(1'b1, 4'hF, 1'b1);
      end
      cyc(1'b1, 4'h0, 1'b0);
    end
  endtask

  task automatic test_overflow();
    int ovf_cnt;
    int g1;
    do_reset();
    cyc(1'b1, 4'b0001, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0);
    n_tests++;
    if (gnt_valid !== 1'b1 || gnt_id !== 2'd0) begin
      n_fail++; $display("FAIL ovf_setup: got gv=%b id=%0d want gv=1 id=0", gnt_valid, gnt_id);
    end
    ovf_cnt = 0;
    cyc(1'b1, 4'b0011, 1'b0); ovf_cnt += int'(overflow);
    cyc(1'b1, 4'b0001, 1'b0); ovf_cnt += int'(overflow);
    cyc(1'b1, 4'b0011, 1'b0); ovf_cnt += int'(overflow);
    cyc(1'b1, 4'b0011, 1'b0); ovf_cnt += int'(overflow);
    cyc(1'b1, 4'b0011, 1'b0); ovf_cnt += int'(overflow);
    n_tests++;
    if (ovf_cnt !== 1 || pend[1] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pulse: got count=%0d pend1=%b want count=1 pend1=1", ovf_cnt, pend[1]);
    end
    g1 = 0;
    cyc(1'b1, 4'b0011, 1'b1);
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 4'b0011, 1'b1);
      if (gnt_valid && gnt_id == 2'd1) g1++;
    end
    n_tests++;
    if (g1 !== 1) begin
      n_fail++; $display("FAIL ovf_single_grant: got %0d grants to ch1 want 1", g1);
    end
  endtask

  task automatic test_collision();
    int got[$];
    int want[3] = '{1, 2, 0};
    do_reset();
    cyc(1'b1, 4'b0111, 1'b0);
    cyc(1'b1, 4'b0110, 1'b0);
    n_tests++;
    if (gnt_valid !== 1'b1 || gnt_id !== 2'd0) begin
      n_fail++; $display("FAIL coll_setup: got gv=%b id=%0d want gv=1 id=0", gnt_valid, gnt_id);
    end
    cyc(1'b1, 4'b0111, 1'b1);
    n_tests++;
    if (pend !== 4'b0111 || overflow !== 1'b0 || gnt_valid !== 1'b0) begin
      n_fail++; $display("FAIL coll_edge: got pend=%b ovf=%b gv=%b want pend=0111 ovf=0 gv=0", pend, overflow, gnt_valid);
    end
    for (int c = 0; c < 12; c++) begin
      cyc(1'b1, 4'b0111, 1'b1);
      if (gnt_valid) got.push_back(int'(gnt_id));
    end
    n_tests++;
    if (got.size() != 3) begin
      n_fail++; $display("FAIL coll_count: got %0d grants want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (got[k] !== want[k]) begin
          n_fail++; $display("FAIL coll_order[%0d]: got %0d want %0d", k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    cyc(1'b1, 4'b0010, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0);
    cyc(1'b1, 4'b0010, 1'b1);
    cyc(1'b1, 4'b1010, 1'b0);
    cyc(1'b1, 4'b1010, 1'b0);
    n_tests++;
    if (gnt_valid !== 1'b1 || gnt_id !== 2'd3) begin
      n_fail++; $display("FAIL midrst_setup: got gv=%b id=%0d want gv=1 id=3", gnt_valid, gnt_id);
    end
    cyc(1'b0, 4'b0000, 1'b0);
    n_tests++;
    if (gnt_valid !== 1'b0 || pend !== 4'b0000 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear: got gv=%b pend=%b ovf=%b want 0 0000 0", gnt_valid, pend, overflow);
    end
    cyc(1'b1, 4'b1001, 1'b0);
    cyc(1'b1, 4'b1001, 1'b0);
    n_tests++;
    if (gnt_valid !== 1'b1 || gnt_id !== 2'd0) begin
      n_fail++; $display("FAIL midrst_ptr: got gv=%b id=%0d want gv=1 id=0", gnt_valid, gnt_id);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    logic hit;
    do_reset();
    cyc(1'b1, 4'b0010, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0);
    k = 0; hit = 1'b0;
    while (!hit && k < TIMEOUT + 4) begin
      cyc(1'b1, 4'b0010, 1'b0);
      k++;
      if (timeout) begin
        hit = 1'b1;
        n_tests++;
        if (gnt_valid !== 1'b0 || pend[1] !== 1'b0) begin
          n_fail++; $display("FAIL tmo_release: got gv=%b pend1=%b want 0 0", gnt_valid, pend[1]);
        end
      end
    end
    n_tests++;
    if (!hit || k !== TIMEOUT) begin
      n_fail++; $display("FAIL tmo_latency: got hit=%b after %0d cycles want hit=1 after %0d", hit, k, TIMEOUT);
    end
    cyc(1'b1, 4'b0010, 1'b0);
    n_tests++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL tmo_pulse_width: got %b want 0", timeout);
    end
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0);
    for (int c = 0; c < TIMEOUT - 1; c++) cyc(1'b1, 4'b0010, 1'b0);
    cyc(1'b1, 4'b0010, 1'b1);
    n_tests++;
    if (timeout !== 1'b0 || gnt_valid !== 1'b0) begin
      n_fail++; $display("FAIL tmo_done_wins: got tmo=%b gv=%b want 0 0", timeout, gnt_valid);
    end
  endtask
`else
  task automatic test_timeout();
    int held;
    int pulses;
    do_reset();
    cyc(1'b1, 4'b0010, 1'b0);
    held = 0; pulses = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(1'b1, 4'b0010, 1'b0);
      if (gnt_valid && gnt_id == 2'd1) held++;
      if (timeout) pulses++;
    end
    n_tests++;
    if (held !== 40 || pulses !== 0) begin
      n_fail++; $display("FAIL no_tmo_hold: got held=%0d pulses=%0d want 40 0", held, pulses);
    end
    cyc(1'b1, 4'b0010, 1'b1);
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] lv;
    logic         r;
    logic         d;
    lv = '0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      r = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) lv[i] = ~lv[i];
      end
      if (c < 400) d = ($urandom_range(0, 2) == 0);
      else         d = ($urandom_range(0, 24) == 0);
      cyc(r, lv, d);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc%0d: got {gv,id,pend,ovf,tmo}=%b want %b", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst   = 1'b0;
    level = '0;
    done  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_collision();
    test_reset_mid_grant();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
